// File: rtl/bp_update_scheduler.sv
// ============================================================================
// Module      : bp_update_scheduler
// Description : Single write-port scheduler for a branch predictor pattern
//               history table (PHT). After reset it sweeps every table entry
//               to CNT_INIT_VALUE, then serves two write sources:
//                 - flush rollback restores (highest priority, never queued)
//                 - commit-time counter updates, buffered in a small queue
//               A rollback also squashes queued updates to the same index so
//               the restored value cannot be overwritten by stale updates.
//
// Ports       : clk, rst                 clock, synchronous active-high reset
//               PL_stall                 blocks enqueue only
//               upd_valid/index/count/taken  resolved-branch update request
//               rb_valid/index/count     rollback restore request
//               upd_ready                queue accepts an update this cycle
//               tbl_we/waddr/wdata       registered PHT write port
//               init_busy                clear sweep in progress
//               queue_level              occupied queue entries
//               overflow                 sticky; an update was dropped
//               stat_upd_cnt, stat_rb_cnt, stat_squash_cnt
//                                        32-bit event counters, present only
//                                        when BP_SCHED_STAT_EN is defined
//
// Options     : `define BP_SCHED_STAT_EN to add the statistics counters.
//
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_update_scheduler #(
    parameter int INDEX_WIDTH      = 12,
    parameter int CNT_WIDTH        = 2,
    parameter int QUEUE_ADDR_WIDTH = 2,
    parameter int CNT_INIT_VALUE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        PL_stall,
    input  logic                        upd_valid,
    input  logic [INDEX_WIDTH-1:0]      upd_index,
    input  logic [CNT_WIDTH-1:0]        upd_count,
    input  logic                        upd_taken,
    input  logic                        rb_valid,
    input  logic [INDEX_WIDTH-1:0]      rb_index,
    input  logic [CNT_WIDTH-1:0]        rb_count,
    output logic                        upd_ready,
    output logic                        tbl_we,
    output logic [INDEX_WIDTH-1:0]      tbl_waddr,
    output logic [CNT_WIDTH-1:0]        tbl_wdata,
    output logic                        init_busy,
    output logic [QUEUE_ADDR_WIDTH:0]   queue_level,
    output logic                        overflow
`ifdef BP_SCHED_STAT_EN
    ,
    output logic [31:0]                 stat_upd_cnt,
    output logic [31:0]                 stat_rb_cnt,
    output logic [31:0]                 stat_squash_cnt
`endif
);

    localparam int                      c_depth     = 1 << QUEUE_ADDR_WIDTH;
    localparam int                      c_lvl_w     = QUEUE_ADDR_WIDTH + 1;
    localparam int                      c_sq_w      = QUEUE_ADDR_WIDTH + 2;
    localparam logic [c_lvl_w-1:0]      c_lvl_full  = c_lvl_w'(c_depth);
    localparam logic [c_lvl_w-1:0]      c_lvl_one   = c_lvl_w'(1);
    localparam logic [CNT_WIDTH-1:0]    c_cnt_max   = '1;
    localparam logic [CNT_WIDTH-1:0]    c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]    c_cnt_init  = CNT_WIDTH'(CNT_INIT_VALUE);
    localparam logic [INDEX_WIDTH-1:0]  c_last_idx  = '1;
    localparam logic [INDEX_WIDTH-1:0]  c_idx_one   = INDEX_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [INDEX_WIDTH-1:0]     r_clear_ptr;

    logic                       r_tbl_we;
    logic [INDEX_WIDTH-1:0]     r_tbl_waddr;
    logic [CNT_WIDTH-1:0]       r_tbl_wdata;
    logic                       r_overflow;

    // Queue is kept compacted: live entries always occupy slots
    // 0..r_level-1 in age order, so the head is slot 0 and squashed
    // entries vanish in the same cycle they are invalidated.
    logic [INDEX_WIDTH-1:0]     r_q_idx [c_depth];
    logic [CNT_WIDTH-1:0]       r_q_cnt [c_depth];
    logic [c_lvl_w-1:0]         r_level;

    logic [INDEX_WIDTH-1:0]     w_nxt_idx [c_depth];
    logic [CNT_WIDTH-1:0]       w_nxt_cnt [c_depth];
    logic [c_lvl_w-1:0]         w_lvl_nxt;

    logic                       w_run;
    logic                       w_rb;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_drop;
    logic                       w_pop;
    logic                       w_push_squash;
    logic                       w_store;
    logic [CNT_WIDTH-1:0]       w_upd_next;
    logic [c_depth-1:0]         w_occ;
    logic [c_depth-1:0]         w_hit;
    logic [c_depth-1:0]         w_keep;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_run    = (r_state == ST_RUN);
    assign w_rb     = w_run && rb_valid;
    assign w_ready  = w_run && (r_level < c_lvl_full);
    assign w_accept = upd_valid && w_ready && !PL_stall;
    assign w_drop   = w_run && upd_valid && !PL_stall && !w_ready;
    // A rollback owns the write port, so the head stays put that cycle.
    assign w_pop    = w_run && !rb_valid && (r_level != '0);

    // An update arriving alongside a rollback to the same index is older
    // than the restore in program order, so it must not land after it.
    assign w_push_squash = w_accept && w_rb && (upd_index == rb_index);
    assign w_store       = w_accept && !w_push_squash;

    always_comb begin
        w_upd_next = upd_count;
        if (upd_taken) begin
            if (upd_count != c_cnt_max) begin
                w_upd_next = upd_count + c_cnt_one;
            end
        end else begin
            if (upd_count != '0) begin
                w_upd_next = upd_count - c_cnt_one;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_depth; gi++) begin : g_entry_mask
            assign w_occ[gi]  = (r_level > c_lvl_w'(gi));
            assign w_hit[gi]  = w_occ[gi] && w_rb && (r_q_idx[gi] == rb_index);
            assign w_keep[gi] = w_occ[gi] && !w_hit[gi] && !(w_pop && (gi == 0));
        end
    endgenerate

    // Compact surviving entries toward slot 0, then append the new one.
    // Pop and append in the same cycle therefore leave the level unchanged.
    always_comb begin
        w_nxt_idx = r_q_idx;
        w_nxt_cnt = r_q_cnt;
        w_lvl_nxt = '0;
        for (int i = 0; i < c_depth; i++) begin
            if (w_keep[i]) begin
                w_nxt_idx[w_lvl_nxt[QUEUE_ADDR_WIDTH-1:0]] = r_q_idx[i];
                w_nxt_cnt[w_lvl_nxt[QUEUE_ADDR_WIDTH-1:0]] = r_q_cnt[i];
                w_lvl_nxt = w_lvl_nxt + c_lvl_one;
            end
        end
        // w_store implies the queue had a free slot, so the slot is in range.
        if (w_store) begin
            w_nxt_idx[w_lvl_nxt[QUEUE_ADDR_WIDTH-1:0]] = upd_index;
            w_nxt_cnt[w_lvl_nxt[QUEUE_ADDR_WIDTH-1:0]] = w_upd_next;
            w_lvl_nxt = w_lvl_nxt + c_lvl_one;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_clear_ptr == c_last_idx) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Write port and clear sweep
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clear_ptr <= '0;
            r_tbl_we    <= 1'b0;
            r_tbl_waddr <= '0;
            r_tbl_wdata <= '0;
        end else if (!w_run) begin
            r_tbl_we    <= 1'b1;
            r_tbl_waddr <= r_clear_ptr;
            r_tbl_wdata <= c_cnt_init;
            r_clear_ptr <= r_clear_ptr + c_idx_one;
        end else if (rb_valid) begin
            r_tbl_we    <= 1'b1;
            r_tbl_waddr <= rb_index;
            r_tbl_wdata <= rb_count;
        end else if (r_level != '0) begin
            r_tbl_we    <= 1'b1;
            r_tbl_waddr <= r_q_idx[0];
            r_tbl_wdata <= r_q_cnt[0];
        end else begin
            r_tbl_we    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Queue storage and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_q_idx[i] <= '0;
                r_q_cnt[i] <= '0;
            end
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_q_idx <= w_nxt_idx;
            r_q_cnt <= w_nxt_cnt;
            r_level <= w_lvl_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef BP_SCHED_STAT_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [c_sq_w-1:0]  w_sq_num;
    logic [31:0]        r_stat_upd;
    logic [31:0]        r_stat_rb;
    logic [31:0]        r_stat_sq;

    always_comb begin
        w_sq_num = '0;
        for (int i = 0; i < c_depth; i++) begin
            if (w_hit[i]) begin
                w_sq_num = w_sq_num + c_sq_w'(1);
            end
        end
        if (w_push_squash) begin
            w_sq_num = w_sq_num + c_sq_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_upd <= '0;
            r_stat_rb  <= '0;
            r_stat_sq  <= '0;
        end else begin
            if (w_accept) begin
                r_stat_upd <= r_stat_upd + 32'd1;
            end
            if (w_rb) begin
                r_stat_rb <= r_stat_rb + 32'd1;
            end
            r_stat_sq <= r_stat_sq + 32'(w_sq_num);
        end
    end

    assign stat_upd_cnt    = r_stat_upd;
    assign stat_rb_cnt     = r_stat_rb;
    assign stat_squash_cnt = r_stat_sq;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign upd_ready   = w_ready;
    assign tbl_we      = r_tbl_we;
    assign tbl_waddr   = r_tbl_waddr;
    assign tbl_wdata   = r_tbl_wdata;
    assign init_busy   = !w_run;
    assign queue_level = r_level;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
// ============================================================================
// Module      : tb_bp_update_scheduler
// Description : Directed self-checking bench for bp_update_scheduler with a
//               16-entry table, 2-bit counters, 4-deep queue, init value 1.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_update_scheduler;

    logic       clk;
    logic       rst;
    logic       PL_stall;
    logic       upd_valid;
    logic [3:0] upd_index;
    logic [1:0] upd_count;
    logic       upd_taken;
    logic       rb_valid;
    logic [3:0] rb_index;
    logic [1:0] rb_count;
    logic       upd_ready;
    logic       tbl_we;
    logic [3:0] tbl_waddr;
    logic [1:0] tbl_wdata;
    logic       init_busy;
    logic [2:0] queue_level;
    logic       overflow;
`ifdef BP_SCHED_STAT_EN
    logic [31:0] stat_upd_cnt;
    logic [31:0] stat_rb_cnt;
    logic [31:0] stat_squash_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    bp_update_scheduler #(
        .INDEX_WIDTH      (4),
        .CNT_WIDTH        (2),
        .QUEUE_ADDR_WIDTH (2),
        .CNT_INIT_VALUE   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PL_stall    (PL_stall),
        .upd_valid   (upd_valid),
        .upd_index   (upd_index),
        .upd_count   (upd_count),
        .upd_taken   (upd_taken),
        .rb_valid    (rb_valid),
        .rb_index    (rb_index),
        .rb_count    (rb_count),
        .upd_ready   (upd_ready),
        .tbl_we      (tbl_we),
        .tbl_waddr   (tbl_waddr),
        .tbl_wdata   (tbl_wdata),
        .init_busy   (init_busy),
        .queue_level (queue_level),
        .overflow    (overflow)
`ifdef BP_SCHED_STAT_EN
        ,
        .stat_upd_cnt    (stat_upd_cnt),
        .stat_rb_cnt     (stat_rb_cnt),
        .stat_squash_cnt (stat_squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic uv, input logic [3:0] ui, input logic [1:0] uc,
                         input logic ut, input logic rv, input logic [3:0] ri,
                         input logic [1:0] rc);
        upd_valid = uv; upd_index = ui; upd_count = uc; upd_taken = ut;
        rb_valid  = rv; rb_index  = ri; rb_count  = rc;
    endtask

    // Reset, then wait (bounded) for the 16-cycle sweep to finish.
    task automatic reset_and_sweep();
        int n;
        rst = 1'b1; PL_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_vec++;
        if (n != 16) begin
            n_err++;
            $display("FAIL sweep_length: got %0d cycles, expected 16", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; PL_stall = 1'b0;
        drive(1, 4'd3, 2'd1, 1, 1, 4'd2, 2'd2);
        step(); step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_port: got %h expected 00", {tbl_we, tbl_waddr, tbl_wdata});
        end
        n_vec++;
        if ({init_busy, upd_ready, queue_level, overflow} !== 6'b10_000_0) begin
            n_err++;
            $display("FAIL reset_status: got %b expected 100000",
                     {init_busy, upd_ready, queue_level, overflow});
        end
    endtask

    task automatic test_sweep();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            // Inputs are ignored during the sweep.
            drive(1, 4'd9, 2'd3, 1, 1, 4'd9, 2'd0);
            step();
            n_vec++;
            if ({tbl_we, tbl_waddr, tbl_wdata} !== {1'b1, 4'(i), 2'd1}) begin
                n_err++;
                $display("FAIL sweep_write[%0d]: got we=%b a=%0d d=%0d expected we=1 a=%0d d=1",
                         i, tbl_we, tbl_waddr, tbl_wdata, i);
            end
            n_vec++;
            if ({init_busy, upd_ready} !== ((i == 15) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL sweep_busy[%0d]: got busy=%b ready=%b", i, init_busy, upd_ready);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        if ({tbl_we, queue_level, overflow} !== 5'b0_000_0) begin
            n_err++;
            $display("FAIL sweep_idle: got we=%b lvl=%0d ovf=%b expected 0 0 0",
                     tbl_we, queue_level, overflow);
        end
    endtask

    task automatic test_saturating();
        logic [1:0] cnt [3];
        logic       tkn [3];
        logic [1:0] exp [3];
        cnt = '{2'd3, 2'd0, 2'd1};
        tkn = '{1'b1, 1'b0, 1'b1};
        exp = '{2'd3, 2'd0, 2'd2};
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'd5, cnt[k], tkn[k], 0, 0, 0);
            step();
            drive(0, 0, 0, 0, 0, 0, 0);
            n_vec++;
            if ({tbl_we, queue_level} !== 4'b0_001) begin
                n_err++;
                $display("FAIL sat_enq[%0d]: got we=%b lvl=%0d expected we=0 lvl=1",
                         k, tbl_we, queue_level);
            end
            step();
            n_vec++;
            if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd5, exp[k], 3'd0}) begin
                n_err++;
                $display("FAIL sat_write[%0d]: got we=%b a=%0d d=%0d lvl=%0d expected 1 5 %0d 0",
                         k, tbl_we, tbl_waddr, tbl_wdata, queue_level, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 4'd8, 2'd2, 0, 0, 0, 0);
        step();
        drive(1, 4'd9, 2'd2, 1, 0, 0, 0);
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd8, 2'd1, 3'd1}) begin
            n_err++;
            $display("FAIL b2b_first: got we=%b a=%0d d=%0d lvl=%0d expected 1 8 1 1",
                     tbl_we, tbl_waddr, tbl_wdata, queue_level);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd9, 2'd3, 3'd0}) begin
            n_err++;
            $display("FAIL b2b_second: got we=%b a=%0d d=%0d lvl=%0d expected 1 9 3 0",
                     tbl_we, tbl_waddr, tbl_wdata, queue_level);
        end
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata} !== {1'b0, 4'd9, 2'd3}) begin
            n_err++;
            $display("FAIL b2b_hold: got we=%b a=%0d d=%0d expected 0 9 3",
                     tbl_we, tbl_waddr, tbl_wdata);
        end
    endtask

    task automatic test_rollback();
        reset_and_sweep();
        // Non-matching restores to index 15 hold the port so the queue fills.
        drive(1, 4'd3, 2'd1, 1, 1, 4'd15, 2'd0);
        step();
        drive(1, 4'd7, 2'd2, 0, 1, 4'd15, 2'd0);
        step();
        drive(1, 4'd3, 2'd0, 1, 1, 4'd15, 2'd0);
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd15, 2'd0, 3'd3}) begin
            n_err++;
            $display("FAIL rb_fill: got we=%b a=%0d d=%0d lvl=%0d expected 1 15 0 3",
                     tbl_we, tbl_waddr, tbl_wdata, queue_level);
        end
        drive(0, 0, 0, 0, 1, 4'd3, 2'd2);
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd3, 2'd2, 3'd1}) begin
            n_err++;
            $display("FAIL rb_restore: got we=%b a=%0d d=%0d lvl=%0d expected 1 3 2 1",
                     tbl_we, tbl_waddr, tbl_wdata, queue_level);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd7, 2'd1, 3'd0}) begin
            n_err++;
            $display("FAIL rb_survivor: got we=%b a=%0d d=%0d lvl=%0d expected 1 7 1 0",
                     tbl_we, tbl_waddr, tbl_wdata, queue_level);
        end
        step();
        n_vec++;
        if (tbl_we !== 1'b0) begin
            n_err++;
            $display("FAIL rb_no_stale: got we=%b expected 0", tbl_we);
        end
`ifdef BP_SCHED_STAT_EN
        // Three updates; four rollbacks (three index-15 holds plus the index-3 one).
        n_vec++;
        if ({stat_upd_cnt, stat_rb_cnt, stat_squash_cnt} !== {32'd3, 32'd4, 32'd2}) begin
            n_err++;
            $display("FAIL stat_counts: got upd=%0d rb=%0d sq=%0d expected 3 4 2",
                     stat_upd_cnt, stat_rb_cnt, stat_squash_cnt);
        end
`endif
        // Update arriving with a same-index rollback is discarded.
        drive(1, 4'd6, 2'd0, 1, 1, 4'd6, 2'd3);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd6, 2'd3, 3'd0}) begin
            n_err++;
            $display("FAIL rb_same_cycle: got we=%b a=%0d d=%0d lvl=%0d expected 1 6 3 0",
                     tbl_we, tbl_waddr, tbl_wdata, queue_level);
        end
        step();
        n_vec++;
        if (tbl_we !== 1'b0) begin
            n_err++;
            $display("FAIL rb_same_cycle_idle: got we=%b expected 0", tbl_we);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'(i), 2'd1, 1, 1, 4'd15, 2'd1);
            step();
        end
        n_vec++;
        if ({queue_level, upd_ready, overflow} !== 5'b100_0_0) begin
            n_err++;
            $display("FAIL full_level: got lvl=%0d ready=%b ovf=%b expected 4 0 0",
                     queue_level, upd_ready, overflow);
        end
        drive(1, 4'd5, 2'd1, 1, 0, 0, 0);
        step();
        n_vec++;
        if ({overflow, queue_level, tbl_we, tbl_waddr, tbl_wdata} !== {1'b1, 3'd3, 1'b1, 4'd1, 2'd2}) begin
            n_err++;
            $display("FAIL full_drop: got ovf=%b lvl=%0d we=%b a=%0d d=%0d expected 1 3 1 1 2",
                     overflow, queue_level, tbl_we, tbl_waddr, tbl_wdata);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            n_vec++;
            if ({tbl_we, tbl_waddr, tbl_wdata} !== {1'b1, 4'(i), 2'd2}) begin
                n_err++;
                $display("FAIL full_drain[%0d]: got we=%b a=%0d d=%0d expected 1 %0d 2",
                         i, tbl_we, tbl_waddr, tbl_wdata, i);
            end
        end
        step();
        n_vec++;
        if ({tbl_we, queue_level, overflow} !== 5'b0_000_1) begin
            n_err++;
            $display("FAIL full_after: got we=%b lvl=%0d ovf=%b expected 0 0 1 (no dropped write)",
                     tbl_we, queue_level, overflow);
        end
    endtask

    task automatic test_stall();
        reset_and_sweep();
        PL_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 4'(i), 2'd1, 1, (i <= 4), 4'd15, 2'd1);
            step();
        end
        n_vec++;
        if ({queue_level, overflow, upd_ready} !== 5'b000_0_1) begin
            n_err++;
            $display("FAIL stall_block: got lvl=%0d ovf=%b ready=%b expected 0 0 1",
                     queue_level, overflow, upd_ready);
        end
        // Stall does not block a rollback write.
        drive(0, 0, 0, 0, 1, 4'd12, 2'd3);
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata} !== {1'b1, 4'd12, 2'd3}) begin
            n_err++;
            $display("FAIL stall_rb: got we=%b a=%0d d=%0d expected 1 12 3",
                     tbl_we, tbl_waddr, tbl_wdata);
        end
        // Stall does not block draining.
        PL_stall = 1'b0;
        drive(1, 4'd11, 2'd2, 1, 0, 0, 0);
        step();
        PL_stall = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        if ({tbl_we, tbl_waddr, tbl_wdata, queue_level} !== {1'b1, 4'd11, 2'd3, 3'd0}) begin
            n_err++;
            $display("FAIL stall_drain: got we=%b a=%0d d=%0d lvl=%0d expected 1 11 3 0",
                     tbl_we, tbl_waddr, tbl_wdata, queue_level);
        end
        PL_stall = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        for (int i = 10; i <= 12; i++) begin
            drive(1, 4'(i), 2'd0, 1, 1, 4'd14, 2'd0);
            step();
        end
        n_vec++;
        if (queue_level !== 3'd3) begin
            n_err++;
            $display("FAIL mid_fill: got lvl=%0d expected 3", queue_level);
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        n_vec++;
        if ({queue_level, init_busy, upd_ready, tbl_we} !== 6'b000_1_0_0) begin
            n_err++;
            $display("FAIL mid_reset: got lvl=%0d busy=%b ready=%b we=%b expected 0 1 0 0",
                     queue_level, init_busy, upd_ready, tbl_we);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            n_vec++;
            if ({tbl_we, tbl_waddr, tbl_wdata} !== {1'b1, 4'(i), 2'd1}) begin
                n_err++;
                $display("FAIL mid_sweep[%0d]: got we=%b a=%0d d=%0d expected 1 %0d 1",
                         i, tbl_we, tbl_waddr, tbl_wdata, i);
            end
        end
        step();
        n_vec++;
        if ({tbl_we, queue_level, init_busy} !== 5'b0_000_0) begin
            n_err++;
            $display("FAIL mid_after: got we=%b lvl=%0d busy=%b expected 0 0 0",
                     tbl_we, queue_level, init_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        PL_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_sweep();
        test_saturating();
        test_back_to_back();
        test_rollback();
        test_full();
        test_stall();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
